// File: rtl/fht_control.sv
// Sequencer and address generator for an in-place radix-2 FHT spread over four
// ping-pong RAM banks: stage/time counters, read/write addresses, coefficient address.
module fht_control #(
    parameter int A_BIT = 8,
    parameter int LAT   = 4
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    output logic             oST_ZERO,
    output logic             oST_LAST,
    output logic             o2ND_PART_SUBSEC,
    output logic [A_BIT-1:0] oSECTOR,
    output logic [A_BIT-1:0] oADDR_RD_0,
    output logic [A_BIT-1:0] oADDR_RD_1,
    output logic [A_BIT-1:0] oADDR_RD_2,
    output logic [A_BIT-1:0] oADDR_RD_3,
    output logic [A_BIT-1:0] oADDR_WR_0,
    output logic [A_BIT-1:0] oADDR_WR_1,
    output logic [A_BIT-1:0] oADDR_WR_2,
    output logic [A_BIT-1:0] oADDR_WR_3,
    output logic [A_BIT-1:0] oADDR_COEF,
    output logic             oWE_A,
    output logic             oWE_B,
    output logic             oSOURCE_DATA,
    output logic [1:0]       oSOURCE_CONT,
    output logic             oRDY
);
    localparam int BANK_SIZE = 1 << A_BIT;
    localparam int STAGES    = A_BIT + 2;
    localparam int T_W       = $clog2(BANK_SIZE + LAT);
    localparam int S_W       = $clog2(STAGES);
    localparam logic [T_W-1:0] T_LAST = T_W'(BANK_SIZE + LAT - 1);
    localparam logic [T_W-1:0] T_BANK = T_W'(BANK_SIZE);
    localparam logic [T_W-1:0] T_LAT  = T_W'(LAT);
    localparam logic [S_W-1:0] S_LAST = S_W'(STAGES - 1);
    localparam logic [S_W-1:0] S_ABIT = S_W'(A_BIT);
    localparam logic [S_W-1:0] S_ONE  = S_W'(1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [S_W-1:0]   stage_q, stage_d;
    logic [T_W-1:0]   time_q, time_d;
    logic [A_BIT-1:0] rd_hold_q;
    logic [A_BIT-1:0] rd_pipe_q [LAT];
    logic             busy;
    logic             wr_active;
    logic [A_BIT-1:0] rd_now;
    logic [A_BIT-1:0] rd_addr;
    logic [A_BIT-1:0] wr_addr;
    logic [T_W-1:0]   t_shift;
    logic [T_W-1:0]   coef_mask;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        time_d  = time_q;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    time_d  = '0;
                end
            end
            ST_RUN: begin
                if (time_q == T_LAST) begin
                    time_d = '0;
                    if (stage_q == S_LAST) begin
                        state_d = ST_IDLE;
                        stage_d = '0;
                    end else begin
                        stage_d = stage_q + S_ONE;
                    end
                end else begin
                    time_d = time_q + T_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q   <= ST_IDLE;
            stage_q   <= '0;
            time_q    <= '0;
            rd_hold_q <= '0;
            for (int i = 0; i < LAT; i++) rd_pipe_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            time_q    <= time_d;
            rd_hold_q <= rd_addr;
            // Delay line is flushed while idle so a new run never sees stale addresses.
            rd_pipe_q[0] <= busy ? rd_addr : '0;
            for (int i = 1; i < LAT; i++) rd_pipe_q[i] <= busy ? rd_pipe_q[i-1] : '0;
        end
    end

    assign busy = (state_q == ST_RUN);

    // Stage 0 reads in bit-reversed order so later stages work in natural order.
    always_comb begin
        rd_now = time_q[A_BIT-1:0];
        if (stage_q == '0) begin
            for (int i = 0; i < A_BIT; i++) rd_now[i] = time_q[A_BIT-1-i];
        end
    end

    assign rd_addr   = !busy ? '0 : (time_q < T_BANK) ? rd_now : rd_hold_q;
    assign wr_addr   = busy ? rd_pipe_q[LAT-1] : '0;
    assign wr_active = busy && (time_q >= T_LAT);

    assign oADDR_RD_0 = rd_addr;
    assign oADDR_RD_1 = rd_addr;
    assign oADDR_RD_2 = rd_addr;
    assign oADDR_RD_3 = rd_addr;
    assign oADDR_WR_0 = wr_addr;
    assign oADDR_WR_1 = wr_addr;
    assign oADDR_WR_2 = wr_addr;
    assign oADDR_WR_3 = wr_addr;
    assign oWE_A      = wr_active & stage_q[0];
    assign oWE_B      = wr_active & ~stage_q[0];
    assign oRDY       = ~busy;

    always_comb begin
        oST_ZERO         = 1'b0;
        oST_LAST         = 1'b0;
        o2ND_PART_SUBSEC = 1'b0;
        oSECTOR          = '0;
        oADDR_COEF       = '0;
        oSOURCE_DATA     = 1'b0;
        oSOURCE_CONT     = 2'd0;
        t_shift          = '0;
        coef_mask        = '0;
        if (busy) begin
            oST_ZERO     = (stage_q == '0);
            oST_LAST     = (stage_q == S_LAST);
            oSOURCE_DATA = stage_q[0];
            if (stage_q != '0 && stage_q < S_ABIT) begin
                t_shift          = time_q >> (stage_q - S_ONE);
                o2ND_PART_SUBSEC = t_shift[0];
                oSECTOR          = A_BIT'(time_q >> stage_q);
                coef_mask        = (T_W'(1) << (stage_q - S_ONE)) - T_W'(1);
                oADDR_COEF       = A_BIT'((time_q & coef_mask) << (S_W'(A_BIT + 1) - stage_q));
            end else if (stage_q >= S_ABIT) begin
                oADDR_COEF = time_q[A_BIT-1:0];
            end
            if (stage_q == S_ABIT)              oSOURCE_CONT = 2'd1;
            else if (stage_q == S_ABIT + S_ONE) oSOURCE_CONT = 2'd2;
        end
    end
endmodule

// File: tb/tb_fht_control.sv
// Self-checking bench for fht_control: per-cycle reference model, write-address
// scoreboard queue, and a table of hand-computed subsection/coefficient vectors.
module tb_fht_control;
    localparam int A_BIT     = 8;
    localparam int LAT       = 4;
    localparam int BS        = 256;
    localparam int STAGE_LEN = 260;
    localparam int TOTAL     = 2600;

    logic       iCLK = 1'b0;
    logic       iRESET = 1'b0;
    logic       iSTART = 1'b0;
    logic       oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
    logic [7:0] oSECTOR, oADDR_COEF;
    logic [7:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
    logic [7:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
    logic       oWE_A, oWE_B, oSOURCE_DATA, oRDY;
    logic [1:0] oSOURCE_CONT;

    fht_control #(.A_BIT(A_BIT), .LAT(LAT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
        .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST), .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC),
        .oSECTOR(oSECTOR),
        .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1),
        .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
        .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
        .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
        .oADDR_COEF(oADDR_COEF), .oWE_A(oWE_A), .oWE_B(oWE_B),
        .oSOURCE_DATA(oSOURCE_DATA), .oSOURCE_CONT(oSOURCE_CONT), .oRDY(oRDY)
    );

    // Clock / watchdog
    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic       rdy;
        logic       we_a;
        logic       we_b;
        logic       sd;
        logic [1:0] cont;
        logic       st_zero;
        logic       st_last;
        logic       second;
        logic [7:0] sector;
        logic [7:0] rd0;
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic [7:0] rd3;
        logic [7:0] coef;
    } out_t;

    typedef struct {
        int         s;
        int         t;
        logic       second;
        logic [7:0] sector;
        logic [7:0] coef;
        logic [1:0] cont;
        logic       sd;
    } vec_t;

    vec_t       vecs[10];
    int         br[4];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         we_cnt = 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    // Reference model
    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [7:0] model_rd(input int s, input int t);
        logic [7:0] tv;
        tv = 8'((t < BS) ? t : BS - 1);
        return (s == 0) ? bitrev8(tv) : tv;
    endfunction

    function automatic out_t model_out(input int k);
        out_t o;
        int   s, t;
        o = '0;
        if (k < 0 || k >= TOTAL) begin
            o.rdy = 1'b1;
            return o;
        end
        s = k / STAGE_LEN;
        t = k % STAGE_LEN;
        o.st_zero = (s == 0);
        o.st_last = (s == 9);
        o.sd      = (s % 2 == 1);
        o.we_a    = (t >= LAT) && (s % 2 == 1);
        o.we_b    = (t >= LAT) && (s % 2 == 0);
        o.rd0     = model_rd(s, t);
        o.rd1     = o.rd0;
        o.rd2     = o.rd0;
        o.rd3     = o.rd0;
        if (s >= 1 && s <= 7) begin
            o.second = ((t >> (s - 1)) & 1) == 1;
            o.sector = 8'(t >> s);
            o.coef   = 8'((t & ((1 << (s - 1)) - 1)) << (9 - s));
        end else if (s >= 8) begin
            o.coef = 8'(t);
        end
        o.cont = (s == 8) ? 2'd1 : (s == 9) ? 2'd2 : 2'd0;
        return o;
    endfunction

    function automatic out_t get_dut();
        out_t o;
        o.rdy = oRDY; o.we_a = oWE_A; o.we_b = oWE_B; o.sd = oSOURCE_DATA;
        o.cont = oSOURCE_CONT; o.st_zero = oST_ZERO; o.st_last = oST_LAST;
        o.second = o2ND_PART_SUBSEC; o.sector = oSECTOR;
        o.rd0 = oADDR_RD_0; o.rd1 = oADDR_RD_1; o.rd2 = oADDR_RD_2; o.rd3 = oADDR_RD_3;
        o.coef = oADDR_COEF;
        return o;
    endfunction

    // Scoreboard
    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s k=%0d: got %h want %h", name, k, act, exp);
        end
    endtask

    task automatic check_cycle(input int k);
        int         s, t;
        logic [7:0] e;
        check("outputs", k, 64'(get_dut()), 64'(model_out(k)));
        if (k < 0 || k >= TOTAL) return;
        s = k / STAGE_LEN;
        t = k % STAGE_LEN;
        if (t < BS) exp_q.push_back(model_rd(s, t));
        if (oWE_A || oWE_B) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_queue k=%0d: got write with empty queue want none", k);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", k, {oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3}, {e, e, e, e});
            end
        end
        if (t == STAGE_LEN - 1) begin
            check("we_per_stage", k, 64'(we_cnt), 64'(BS));
            check("queue_drain", k, 64'(exp_q.size()), 64'(0));
            we_cnt = 0;
        end
        if (k < 4) check("bitrev_start", k, 64'(oADDR_RD_0), 64'(br[k]));
        foreach (vecs[i]) begin
            if (vecs[i].s == s && vecs[i].t == t)
                check($sformatf("vec%0d", i), k,
                      {o2ND_PART_SUBSEC, oSECTOR, oADDR_COEF, oSOURCE_CONT, oSOURCE_DATA},
                      {vecs[i].second, vecs[i].sector, vecs[i].coef, vecs[i].cont, vecs[i].sd});
        end
    endtask

    // Driver tasks
    task automatic pulse_start();
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
    endtask

    initial begin
        //            s  t    2nd sector coef cont sd
        vecs[0] = '{3,  13, 1'b1, 8'd1, 8'd64,  2'd0, 1'b1};
        vecs[1] = '{1,  5,  1'b1, 8'd2, 8'd0,   2'd0, 1'b1};
        vecs[2] = '{2,  7,  1'b1, 8'd1, 8'd128, 2'd0, 1'b0};
        vecs[3] = '{7,  200, 1'b1, 8'd1, 8'd32, 2'd0, 1'b1};
        vecs[4] = '{8,  77, 1'b0, 8'd0, 8'd77,  2'd1, 1'b0};
        vecs[5] = '{9,  255, 1'b0, 8'd0, 8'd255, 2'd2, 1'b1};
        vecs[6] = '{0,  3,  1'b0, 8'd0, 8'd0,   2'd0, 1'b0};
        vecs[7] = '{4,  100, 1'b0, 8'd6, 8'd128, 2'd0, 1'b0};
        vecs[8] = '{5,  31, 1'b1, 8'd0, 8'd240, 2'd0, 1'b1};
        vecs[9] = '{6,  259, 1'b0, 8'd4, 8'd24, 2'd0, 1'b0};
        br = '{0, 128, 64, 192};

        // Reset and idle
        iRESET = 1'b0;
        iSTART = 1'b0;
        repeat (3) @(negedge iCLK);
        check_cycle(-1);
        iRESET = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge iCLK);
            check_cycle(-1);
        end

        // Full transform with a stray start pulse mid-run
        pulse_start();
        for (int k = 0; k <= TOTAL + 4; k++) begin
            check_cycle(k);
            iSTART = (k == 1000);
            @(negedge iCLK);
        end
        iSTART = 1'b0;

        // Second run, aborted by reset in stage 5
        pulse_start();
        for (int k = 0; k < 5 * STAGE_LEN + 17; k++) begin
            check_cycle(k);
            @(negedge iCLK);
        end
        check_cycle(5 * STAGE_LEN + 17);
        #2;
        iRESET = 1'b0;
        #1;
        check_cycle(-1);
        check("abort_we", -1, {oWE_A, oWE_B}, 2'b00);
        exp_q.delete();
        we_cnt = 0;
        @(negedge iCLK);
        iRESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            check_cycle(-1);
        end

        // Clean restart after abort
        pulse_start();
        for (int k = 0; k < 300; k++) begin
            check_cycle(k);
            @(negedge iCLK);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
